quire_to_posit_4_0: RTL and testbench

Converts the 20-bit two's-complement quire stream produced by the posit<4,0> accumulator into rounded posit<4,0> encodings. It sits directly downstream of the accumulator, on the same rts/rtr/sow/eow handshake. It produces the final dot-product result as a 4-bit posit plus flags. It is a 3-stage pipeline with round-to-nearest-even, saturation to maxpos, and no underflow to zero.

---
 rtl/quire_to_posit_4_0_pkg.sv | 20 ++
 rtl/quire_round_4_0.sv | 22 ++
 rtl/quire_to_posit_4_0.sv | 143 ++++++++++++++
 tb/tb_quire_to_posit_4_0.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/quire_to_posit_4_0_pkg.sv
// Shared constants for the posit<4,0> quire-to-posit converter.
package posit_defines;

    localparam int QUIRE_4_0_SIZE = 20;

    localparam logic [3:0] POSIT_4_0_NAR = 4'b1000;

    // Upper edge (inclusive) of each body code's magnitude range, in quire LSBs.
    // Tie points sit on the even body code: 6->010, 10->010, 14->100, 28->110, 48->110.
    localparam logic [6:0] RND_T1 = 7'd5;
    localparam logic [6:0] RND_T2 = 7'd10;
    localparam logic [6:0] RND_T3 = 7'd13;
    localparam logic [6:0] RND_T4 = 7'd20;
    localparam logic [6:0] RND_T5 = 7'd27;
    localparam logic [6:0] RND_T6 = 7'd48;

    // Magnitudes at or above this value all round to maxpos.
    localparam logic [6:0] MC_SAT = 7'd64;

endpackage

// File: rtl/quire_round_4_0.sv
// Combinational threshold map from clipped quire magnitude to posit<4,0> body bits.
module quire_round_4_0
    import posit_defines::*;
(
    input  logic [6:0] mc_i,
    output logic [2:0] body_o
);

    // Pick the body code whose magnitude range contains mc_i.
    always_comb begin
        body_o = 3'b000;
        if (mc_i == 7'd0)         body_o = 3'b000;
        else if (mc_i <= RND_T1)  body_o = 3'b001;
        else if (mc_i <= RND_T2)  body_o = 3'b010;
        else if (mc_i <= RND_T3)  body_o = 3'b011;
        else if (mc_i <= RND_T4)  body_o = 3'b100;
        else if (mc_i <= RND_T5)  body_o = 3'b101;
        else if (mc_i <= RND_T6)  body_o = 3'b110;
        else                      body_o = 3'b111;
    end

endmodule

// File: rtl/quire_to_posit_4_0.sv
// Three-stage quire (20-bit, LSB 2^-4) to posit<4,0> converter with rts/rtr handshake.
// Optional build macro: QUIRE_EOW_FILTER_EN - emit only end-of-window beats, sow_o forced high.
module quire_to_posit_4_0
    import posit_defines::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      rtr_o,
    input  logic                      rts_i,
    input  logic                      sow_i,
    input  logic                      eow_i,
    input  logic [QUIRE_4_0_SIZE-1:0] data_i,
    input  logic                      sign_i,
    input  logic                      zero_i,
    input  logic                      NaR_i,
    input  logic                      rtr_i,
    output logic                      rts_o,
    output logic                      sow_o,
    output logic                      eow_o,
    output logic [3:0]                posit_o,
    output logic                      sign_o,
    output logic                      zero_o,
    output logic                      NaR_o
);

    logic                      process_en;
    logic                      s1_in_vld;
    logic                      s1_sow_in;
    logic                      s1_vld_q, s1_sow_q, s1_eow_q, s1_zero_q, s1_nar_q;
    logic [QUIRE_4_0_SIZE-1:0] s1_data_q;
    logic                      s2_vld_q, s2_sow_q, s2_eow_q, s2_zero_q, s2_nar_q, s2_sgn_q;
    logic [6:0]                s2_mc_q;
    logic [QUIRE_4_0_SIZE-1:0] s2_mag_d;
    logic [6:0]                s2_mc_d;
    logic                      s2_sgn_d;
    logic [2:0]                s3_body;
    logic [3:0]                s3_posit_d;
    logic                      s3_sign_d, s3_zero_d, s3_nar_d;

    // The whole pipe advances together; it only stalls when the output is held.
    assign process_en = rtr_i | ~rts_o;
    assign rtr_o      = process_en;

`ifdef QUIRE_EOW_FILTER_EN
    assign s1_in_vld = rts_i & eow_i;
    assign s1_sow_in = sow_i | 1'b1;
`else
    assign s1_in_vld = rts_i;
    assign s1_sow_in = sow_i;
`endif

    // S1: capture the accepted beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
        end else if (process_en) begin
            s1_vld_q <= s1_in_vld;
            if (s1_in_vld) begin
                s1_data_q <= data_i;
                s1_sow_q  <= s1_sow_in;
                s1_eow_q  <= eow_i;
                s1_zero_q <= zero_i;
                s1_nar_q  <= NaR_i;
            end
        end
    end

    // S2 combinational: magnitude and clip. sign_i only mirrors data_i[19], which decides.
    always_comb begin
        s2_sgn_d = s1_data_q[QUIRE_4_0_SIZE-1];
        s2_mag_d = s2_sgn_d ? (~s1_data_q + 1'b1) : s1_data_q;
        s2_mc_d  = (s2_mag_d >= {13'd0, MC_SAT}) ? MC_SAT : s2_mag_d[6:0];
    end

    // S2: register clipped magnitude, sign and the zero/NaR classification.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_vld_q <= 1'b0;
        end else if (process_en) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_mc_q   <= s2_mc_d;
                s2_sgn_q  <= s2_sgn_d;
                s2_zero_q <= s1_zero_q | (s2_mag_d == '0);
                s2_nar_q  <= s1_nar_q;
                s2_sow_q  <= s1_sow_q;
                s2_eow_q  <= s1_eow_q;
            end
        end
    end

    quire_round_4_0 u_round (
        .mc_i   (s2_mc_q),
        .body_o (s3_body)
    );

    // S3 combinational: NaR beats zero beats the rounded, sign-applied body.
    always_comb begin
        s3_posit_d = {1'b0, s3_body};
        s3_sign_d  = s2_sgn_q;
        s3_zero_d  = 1'b0;
        s3_nar_d   = 1'b0;
        if (s2_nar_q) begin
            s3_posit_d = POSIT_4_0_NAR;
            s3_sign_d  = 1'b1;
            s3_nar_d   = 1'b1;
        end else if (s2_zero_q) begin
            s3_posit_d = 4'b0000;
            s3_sign_d  = 1'b0;
            s3_zero_d  = 1'b1;
        end else if (s2_sgn_q) begin
            s3_posit_d = 4'd0 - {1'b0, s3_body};
        end
    end

    // S3: output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rts_o   <= 1'b0;
            posit_o <= 4'b0000;
            sow_o   <= 1'b0;
            eow_o   <= 1'b0;
            sign_o  <= 1'b0;
            zero_o  <= 1'b0;
            NaR_o   <= 1'b0;
        end else if (process_en) begin
            rts_o <= s2_vld_q;
            if (s2_vld_q) begin
                posit_o <= s3_posit_d;
                sow_o   <= s2_sow_q;
                eow_o   <= s2_eow_q;
                sign_o  <= s3_sign_d;
                zero_o  <= s3_zero_d;
                NaR_o   <= s3_nar_d;
            end
        end
    end

    // sign_i is informational only; keep it formally consumed without affecting logic.
    logic sign_unused;
    assign sign_unused = sign_i & 1'b0;

endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// Directed-vector bench for quire_to_posit_4_0.
module tb_quire_to_posit_4_0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rtr_o, rts_i, sow_i, eow_i, sign_i, zero_i, NaR_i, rtr_i;
    logic [19:0] data_i;
    logic        rts_o, sow_o, eow_o, sign_o, zero_o, NaR_o;
    logic [3:0]  posit_o;

    int n_vec = 0;
    int n_err = 0;

`ifdef QUIRE_EOW_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    always #5 clk = ~clk;

    quire_to_posit_4_0 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rtr_o   (rtr_o),
        .rts_i   (rts_i),
        .sow_i   (sow_i),
        .eow_i   (eow_i),
        .data_i  (data_i),
        .sign_i  (sign_i),
        .zero_i  (zero_i),
        .NaR_i   (NaR_i),
        .rtr_i   (rtr_i),
        .rts_o   (rts_o),
        .sow_o   (sow_o),
        .eow_o   (eow_o),
        .posit_o (posit_o),
        .sign_o  (sign_o),
        .zero_o  (zero_o),
        .NaR_o   (NaR_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single beat through an empty pipe; checks latency, encoding and flags.
    task automatic send_one(input string tag, input logic [19:0] d, input logic z,
                            input logic n, input logic sw, input logic ew,
                            input logic [3:0] ep, input logic es, input logic ez,
                            input logic en);
        int lat;
        bit seen;
        @(posedge clk); #1;
        rts_i = 1'b1; data_i = d; sign_i = d[19]; zero_i = z; NaR_i = n;
        sow_i = sw; eow_i = ew; rtr_i = 1'b1;
        chk({tag, "_rtr"}, rtr_o, 1);
        @(posedge clk); #1;
        rts_i = 1'b0; zero_i = 1'b0; NaR_i = 1'b0;
        lat = 1; seen = 1'b0;
        while (!seen && lat < 10) begin
            if (rts_o) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
        else begin
            chk({tag, "_lat"}, lat, 3);
            chk({tag, "_posit"}, posit_o, ep);
            chk({tag, "_sign"}, sign_o, es);
            chk({tag, "_zero"}, zero_o, ez);
            chk({tag, "_nar"}, NaR_o, en);
            chk({tag, "_sow"}, sow_o, FILT ? 1'b1 : sw);
            chk({tag, "_eow"}, eow_o, ew);
        end
    endtask

    logic [19:0] s_data [8] = '{20'd16, 20'd24, 20'd64, 20'd4, 20'hFFFF0, 20'd28, 20'd49, 20'd6};
    logic [3:0]  s_exp  [8] = '{4'b0100, 4'b0101, 4'b0111, 4'b0001, 4'b1100, 4'b0110, 4'b0111, 4'b0010};
    bit          r_pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int in_idx, out_idx, extra;
        bit held_vld;
        logic [3:0] held_val;
        logic [3:0] cap;

        rst_n = 1'b0; rts_i = 1'b0; sow_i = 1'b0; eow_i = 1'b1; data_i = '0;
        sign_i = 1'b0; zero_i = 1'b0; NaR_i = 1'b0; rtr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rts", rts_o, 0);
        chk("rst_posit", posit_o, 0);
        chk("rst_flags", {sow_o, eow_o, sign_o, zero_o, NaR_o}, 0);
        chk("rst_rtr", rtr_o, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_rtr", rtr_o, 1);

        send_one("p16",  20'd16,    0, 0, 1, 1, 4'b0100, 0, 0, 0);
        send_one("p24",  20'd24,    0, 0, 0, 1, 4'b0101, 0, 0, 0);
        send_one("p64",  20'd64,    0, 0, 0, 1, 4'b0111, 0, 0, 0);
        send_one("p4",   20'd4,     0, 0, 0, 1, 4'b0001, 0, 0, 0);
        send_one("n16",  20'hFFFF0, 0, 0, 0, 1, 4'b1100, 1, 0, 0);
        send_one("n4",   20'hFFFFC, 0, 0, 0, 1, 4'b1111, 1, 0, 0);
        send_one("t28",  20'd28,    0, 0, 0, 1, 4'b0110, 0, 0, 0);
        send_one("t48",  20'd48,    0, 0, 0, 1, 4'b0110, 0, 0, 0);
        send_one("t49",  20'd49,    0, 0, 0, 1, 4'b0111, 0, 0, 0);
        send_one("t14",  20'd14,    0, 0, 0, 1, 4'b0100, 0, 0, 0);
        send_one("t6",   20'd6,     0, 0, 0, 1, 4'b0010, 0, 0, 0);
        send_one("t10",  20'd10,    0, 0, 0, 1, 4'b0010, 0, 0, 0);
        send_one("t2",   20'd2,     0, 0, 0, 1, 4'b0001, 0, 0, 0);
        send_one("maxq", 20'h7FFFF, 0, 0, 0, 1, 4'b0111, 0, 0, 0);
        send_one("minq", 20'h80000, 0, 0, 0, 1, 4'b1001, 1, 0, 0);
        send_one("zero", 20'd0,     0, 0, 0, 1, 4'b0000, 0, 1, 0);
        send_one("zflg", 20'd16,    1, 0, 0, 1, 4'b0000, 0, 1, 0);
        send_one("nar",  20'd16,    0, 1, 0, 1, 4'b1000, 1, 0, 1);
        if (!FILT) send_one("sweow", 20'd24, 0, 0, 1, 0, 4'b0101, 0, 0, 0);

        // Backpressured stream: rtr_i follows 1,0,0,1 each cycle.
        @(posedge clk); #1;
        sow_i = 1'b0; eow_i = 1'b1;
        in_idx = 0; out_idx = 0; held_vld = 1'b0; held_val = '0;
        for (int cyc = 0; cyc < 200 && out_idx < 8; cyc++) begin
            @(posedge clk); #1;
            rtr_i  = r_pat[cyc % 4];
            rts_i  = (in_idx < 8);
            data_i = s_data[in_idx % 8];
            sign_i = data_i[19];
            #4;
            if (held_vld) chk("hold", {rts_o, posit_o}, {1'b1, held_val});
            if (rts_o && rtr_i) begin
                if (out_idx < 8) chk("stream", posit_o, s_exp[out_idx]);
                out_idx++;
            end
            if (rts_i && rtr_o) in_idx++;
            held_vld = rts_o & ~rtr_i;
            held_val = posit_o;
        end
        chk("stream_cnt", out_idx, 8);
        @(posedge clk); #1;
        rts_i = 1'b0; rtr_i = 1'b1;
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rts_o) extra++;
        end
        chk("no_dup", extra, 0);

        // Reset with beats in every stage.
        rts_i = 1'b1; data_i = 20'd16; sign_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_rts", rts_o, 1);
        rst_n = 1'b0; rts_i = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_rts", rts_o, 0);
        chk("mid_rst_rtr", rtr_o, 1);
        rst_n = 1'b1;
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rts_o) extra++;
        end
        chk("rst_flush", extra, 0);

        if (FILT) begin
            // Window 16, 8, 4 with eow only on the last beat.
            @(posedge clk); #1;
            rts_i = 1'b1; sow_i = 1'b1; eow_i = 1'b0; data_i = 20'd16; sign_i = 1'b0;
            @(posedge clk); #1;
            sow_i = 1'b0; data_i = 20'd8;
            @(posedge clk); #1;
            eow_i = 1'b1; data_i = 20'd4;
            @(posedge clk); #1;
            rts_i = 1'b0;
            extra = 0; cap = '0;
            repeat (8) begin
                if (rts_o) begin
                    extra++;
                    cap = posit_o;
                    chk("filt_flags", {sow_o, eow_o}, 2'b11);
                end
                @(posedge clk); #1;
            end
            chk("filt_cnt", extra, 1);
            chk("filt_val", cap, 4'b0001);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
